// File: rtl/rf_write_arbiter_if.sv
// Write-port bus between the writeback requesters and the register-file write arbiter.
// master = requester side, slave = arbiter side.
interface rf_write_arbiter_if #(
    parameter int NUM_REQ = 3,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        lock;
    logic [NUM_REQ*ADDR_W-1:0] req_rd;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic                      stall;
    logic [NUM_REQ-1:0]        gnt;
    logic                      RegWrite;
    logic [ADDR_W-1:0]         Rd;
    logic [DATA_W-1:0]         Write_data;
    logic [2:0]                owner;

    modport master (
        output req, lock, req_rd, req_data, stall,
        input  gnt, RegWrite, Rd, Write_data, owner
    );

    modport slave (
        input  req, lock, req_rd, req_data, stall,
        output gnt, RegWrite, Rd, Write_data, owner
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter for the register file's single write port, with bounded locked
// bursts and silent dropping of x0 writes. Write signals are registered one cycle after grant.
module rf_write_arbiter #(
    parameter int NUM_REQ   = 3,
    parameter int ADDR_W    = 5,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 4
) (
    input logic               i_clk,
    input logic               i_reset,
    rf_write_arbiter_if.slave io_arb
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {ARB, LOCKED} state_t;

    state_t             r_state, w_state_nx;
    logic [IDX_W-1:0]   r_ptr, w_ptr_nx;
    logic [IDX_W-1:0]   r_lk_owner, w_lk_nx;
    logic [CNT_W-1:0]   r_burst_cnt, w_cnt_nx;
    logic [IDX_W-1:0]   w_sel;
    logic               w_xfer;
    logic [NUM_REQ-1:0] w_gnt;
    logic [ADDR_W-1:0]  w_sel_rd;
    logic [DATA_W-1:0]  w_sel_data;
    logic               r_regwrite;
    logic [ADDR_W-1:0]  r_rd;
    logic [DATA_W-1:0]  r_wdata;
    logic [2:0]         r_owner;

    function automatic logic [IDX_W-1:0] f_inc(input logic [IDX_W-1:0] i);
        return (int'(i) == NUM_REQ - 1) ? '0 : i + IDX_W'(1);
    endfunction

    function automatic logic [IDX_W-1:0] f_rot(input logic [IDX_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return IDX_W'(s);
    endfunction

    always_comb begin
        w_state_nx = r_state;
        w_ptr_nx   = r_ptr;
        w_lk_nx    = r_lk_owner;
        w_cnt_nx   = r_burst_cnt;
        w_gnt      = '0;
        w_sel      = r_lk_owner;
        w_xfer     = 1'b0;
        // stall and reset leave every next-state equal to the current one
        if (!i_reset && !io_arb.stall) begin
            case (r_state)
                ARB: begin
                    // scan farthest-first so the requester nearest ptr overrides
                    for (int k = NUM_REQ - 1; k >= 0; k--) begin
                        if (io_arb.req[f_rot(r_ptr, k)]) begin
                            w_sel  = f_rot(r_ptr, k);
                            w_xfer = 1'b1;
                        end
                    end
                    if (w_xfer) begin
                        w_gnt[w_sel] = 1'b1;
                        if (io_arb.lock[w_sel] && MAX_BURST > 1) begin
                            w_state_nx = LOCKED;
                            w_lk_nx    = w_sel;
                            w_cnt_nx   = CNT_W'(1);
                        end else begin
                            w_ptr_nx = f_inc(w_sel);
                        end
                    end
                end
                LOCKED: begin
                    if (io_arb.req[r_lk_owner]) begin
                        w_xfer            = 1'b1;
                        w_gnt[r_lk_owner] = 1'b1;
                        w_cnt_nx          = r_burst_cnt + CNT_W'(1);
                    end
                    if (!io_arb.req[r_lk_owner] || !io_arb.lock[r_lk_owner] ||
                        int'(r_burst_cnt) + 1 >= MAX_BURST) begin
                        w_state_nx = ARB;
                        w_ptr_nx   = f_inc(r_lk_owner);
                        w_cnt_nx   = '0;
                    end
                end
            endcase
        end
    end

    assign w_sel_rd   = io_arb.req_rd[w_sel*ADDR_W +: ADDR_W];
    assign w_sel_data = io_arb.req_data[w_sel*DATA_W +: DATA_W];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ARB;
            r_ptr       <= '0;
            r_lk_owner  <= '0;
            r_burst_cnt <= '0;
            r_regwrite  <= 1'b0;
            r_rd        <= '0;
            r_wdata     <= '0;
            r_owner     <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_ptr       <= w_ptr_nx;
            r_lk_owner  <= w_lk_nx;
            r_burst_cnt <= w_cnt_nx;
            // x0 transfers are consumed but never reach the register file
            r_regwrite  <= w_xfer && (w_sel_rd != '0);
            if (w_xfer) begin
                r_owner <= 3'(w_sel);
                if (w_sel_rd != '0) begin
                    r_rd    <= w_sel_rd;
                    r_wdata <= w_sel_data;
                end
            end
        end
    end

    assign io_arb.gnt        = w_gnt;
    assign io_arb.RegWrite   = r_regwrite;
    assign io_arb.Rd         = r_rd;
    assign io_arb.Write_data = r_wdata;
    assign io_arb.owner      = r_owner;
endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Round-robin arbiter that shares the register file's single write port (RegWrite/Rd/Write_data) between several writeback sources: ALU writeback, load unit, and the matrix-init loader of the determinant datapath. It accepts one write per cycle under a valid/grant handshake and drives registered write signals into the register file. It supports bounded locked bursts, so one source can stream consecutive writes such as matrix row loads. It silently drops writes to x0.

## Interface
- NUM_REQ, 3, number of requesters (2..8); index 0 = ALU, 1 = load, 2 = init loader
- ADDR_W, 5, register address width
- DATA_W, 32, write data width
- MAX_BURST, 4, maximum consecutive grants in one locked burst (>=1)

- clk  input  1  single clock; all state on rising edge
- reset  input  1  synchronous, active-high; sampled on rising edge of clk
- req  input  NUM_REQ  per-requester write valid
- lock  input  NUM_REQ  per-requester burst-hold request, meaningful only with req
- req_rd  input  NUM_REQ*ADDR_W  packed destination indices, requester i at [i*ADDR_W +: ADDR_W]
- req_data  input  NUM_REQ*DATA_W  packed write data, same packing
- stall  input  1  freeze: no grants, no state change
- gnt  output  NUM_REQ  one-hot (or zero) grant, combinational from registered state and current inputs
- RegWrite  output  1  registered write enable to register file
- Rd  output  ADDR_W  registered write address
- Write_data  output  DATA_W  registered write data
- owner  output  3  registered index of last granted requester (debug)

## Operation
- Transfer for requester i occurs in a cycle where req[i] & gnt[i]; requester must hold req/req_rd/req_data stable until granted.
- At most one gnt bit high per cycle; gnt = 0 whenever stall = 1 or reset = 1.
- State machine: ARB and LOCKED.
- ARB: grant the first requester with req set, searching from ptr upward with wrap (ptr, ptr+1, ..., NUM_REQ-1, 0, ...).
  - After granting i: ptr <= (i+1) mod NUM_REQ.
  - If lock[i] was also set and MAX_BURST > 1: enter LOCKED with lk_owner = i and burst_cnt = 1; ptr is not updated.
- LOCKED: only lk_owner is eligible, and other requests wait.
  - If req[lk_owner] is set: grant it and increment burst_cnt.
  - Exit to ARB with ptr <= (lk_owner+1) mod NUM_REQ when any of the following holds:
    - the granted cycle has lock[lk_owner] = 0;
    - burst_cnt reaches MAX_BURST on this grant;
    - req[lk_owner] = 0, in which case no grant is issued that cycle.
- Write generation, on the cycle after a transfer:
  - RegWrite = 1, Rd = granted req_rd, Write_data = granted req_data.
  - A transfer with req_rd = 0 is granted (consumed) but yields RegWrite = 0.
- No transfer: RegWrite = 0; Rd and Write_data hold their previous values.
- stall = 1: state, ptr, burst_cnt and owner frozen; RegWrite = 0 next cycle.
- owner updates to the granted index on every transfer.

## Timing
- Reset values:
  - RegWrite = 0, Rd = 0, Write_data = 0, owner = 0
  - state = ARB, ptr = 0, burst_cnt = 0, lk_owner = 0
  - gnt = 0 during the reset cycle
- Grant latency: 0 cycles (same cycle as req when eligible).
- Write latency: RegWrite asserted exactly 1 cycle after the transfer edge.
- Throughput: 1 write/cycle sustained.
- Worst-case wait for an unlocked requester: (NUM_REQ-1)*MAX_BURST cycles with no stall.
- Reset asserted mid-burst: returns to ARB, ptr = 0. The write of a transfer accepted in the cycle before reset is lost (RegWrite = 0 after reset).
- stall and reset together: reset wins.
- Simultaneous req on all inputs in ARB: grant the ptr-nearest requester only.

## Test plan
- Reset, then req = 3'b111 with rd = 1,2,3 and data = A,B,C held → gnt 001, 010, 100, 001 on consecutive cycles; RegWrite = 1 each following cycle with Rd 1, 2, 3, 1.
- Requester 2 req+lock for 6 cycles with MAX_BURST = 4 while req[0] is held → gnt[2] for 4 cycles, then gnt[0], then gnt[2] resumes new burst.
- Requester 1 locks, then drops lock on its 2nd grant while req[0] and req[2] are pending → 2 grants to 1, then gnt[2] (ptr = 2), then gnt[0].
- req[0] with rd = 0, data = 32'hDEADBEEF → gnt[0] = 1, next cycle RegWrite = 0, Rd/Write_data unchanged.
- stall = 1 for 3 cycles with req = 3'b011 → gnt = 0 and RegWrite = 0 throughout; after release gnt[ptr-next] resumes, order unchanged.
- Reset asserted during a LOCKED burst of requester 2 → next cycle gnt = 0, RegWrite = 0, outputs zero; after release a req = 3'b110 grants requester 1 first (ptr = 0 search).
